// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer device: register map, CTRL layout, MODE codes, FSM states.
package timer_dev_pkg;

    localparam logic [31:0] DEV_ID_DEFAULT = 32'h0000_7133;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_DEV_ID = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Field order matches the CTRL bit indices above.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // Only 01 reloads; 00 and the reserved 1x codes behave as one-shot.
    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction

endpackage

// File: rtl/timer_fsm.sv
// Timer sequencer: IDLE/LOAD/CNT/INT state, COUNT datapath and the interrupt flag.
// Latency: INT is reached max(PRESET,1)+1 edges after leaving IDLE.
// Backpressure: none; software acks via sw_ack, expiry set beats a same-edge ack.
module timer_fsm
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [31:0] preset,
    input  logic        sw_ack,
    output logic [31:0] count,
    output logic        irq_flag,
    output logic        en_clr
);

    state_t state;

    assign en_clr = (state == ST_INT) && !is_auto(mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (sw_ack)
                irq_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // PRESET of 0 or 1 both expire on the first counting edge.
                        count    <= '0;
                        state    <= ST_INT;
                        irq_flag <= 1'b1;
                    end
                end
                ST_INT: begin
                    if (is_auto(mode))
                        irq_flag <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and a maskable level IRQ.
// Latency: register reads are combinational; writes take effect at the sampling edge.
// Backpressure: none; every write is accepted, writes to COUNT/DEV_ID are dropped.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] DEV_ID = DEV_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        IRQ
);

    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        en_clr;
    logic        wr_ctrl;
    logic        wr_preset;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl   <= '0;
            preset <= '0;
        end else begin
            // A software CTRL write overrides the one-shot EN clear on the same edge.
            if (wr_ctrl)
                ctrl <= ctrl_t'(wdata[CTRL_IM:CTRL_EN]);
            else if (en_clr)
                ctrl.en <= 1'b0;
            if (wr_preset)
                preset <= wdata;
        end
    end

    timer_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl.en),
        .mode     (ctrl.mode),
        .preset   (preset),
        .sw_ack   (wr_ctrl || wr_preset),
        .count    (count),
        .irq_flag (irq_flag),
        .en_clr   (en_clr)
    );

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            ADDR_DEV_ID: rdata = DEV_ID;
            default:     rdata = '0;
        endcase
    end

    assign IRQ = ctrl.im & irq_flag;

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: DEV_ID, 32'h0000_7133, constant returned at register offset 0xC.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: addr  input  2  word select (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=DEV_ID.
REQ-006 Port: we  input  1  register write strobe, sampled on clk.
REQ-007 Port: wdata  input  32  write data.
REQ-008 Port: rdata  output  32  read data, combinational from addr.
REQ-009 Port: IRQ  output  1  level interrupt request, wired to one CP0 ext_int bit.

Function
REQ-010 CTRL SHALL hold EN in bit 0, MODE in bits [2:1] (00 one-shot, 01 auto-reload, 1x treated as one-shot) and IM (interrupt mask) in bit 3; bits [31:4] SHALL read 0.
REQ-011 A write with addr=0 SHALL load CTRL[3:0] from wdata[3:0]; a write with addr=1 SHALL load PRESET from wdata; writes to COUNT and DEV_ID SHALL be ignored.
REQ-012 Reads SHALL return CTRL, PRESET, COUNT or DEV_ID per addr with zero latency.
REQ-013 FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-014 IDLE: EN=1 -> LOAD, else stay; COUNT holds.
REQ-015 LOAD: COUNT <= PRESET; -> CNT.
REQ-016 CNT: EN=0 -> IDLE with COUNT held; else COUNT>1 -> COUNT-1, stay; else (COUNT<=1) COUNT <= 0, -> INT, irq_flag <= 1.
REQ-017 INT, MODE one-shot: CTRL.EN <= 0, irq_flag stays 1, -> IDLE.
REQ-018 INT, MODE auto-reload: EN unchanged, irq_flag <= 0 on leaving, -> IDLE, so the timer reloads and restarts.
REQ-019 IRQ SHALL equal IM & irq_flag.
REQ-020 Latency: with PRESET=N>=1, a CTRL write setting EN at edge E0 SHALL enter INT at edge E(N+2); IRQ high from that edge.
REQ-021 PRESET=0 SHALL behave as PRESET=1.
REQ-022 Auto-reload period SHALL be N+3 cycles with IRQ high exactly one cycle per period.
REQ-023 Any write to CTRL or PRESET SHALL clear irq_flag (software acknowledge), except on an edge where the FSM sets irq_flag, where the set wins.
REQ-024 A PRESET write during CNT SHALL NOT change COUNT until the next LOAD.
REQ-025 A software CTRL write on the same edge as the INT-state one-shot EN clear SHALL win (CTRL takes wdata).
REQ-026 MODE SHALL be sampled in INT; changing MODE mid-count affects only the current expiry.
REQ-027 COUNT arithmetic SHALL be 32-bit unsigned; COUNT SHALL never wrap below 0.

Reset
REQ-028 On rst, CTRL, PRESET, COUNT and irq_flag SHALL become 0 and the state IDLE at that edge; IRQ=0 and rdata reflect reset values the following cycle.
REQ-029 rst SHALL override any simultaneous write or FSM transition, including mid-count.

Structure
REQ-030 A shared package SHALL hold register offsets, CTRL bit indices, MODE codes and FSM state encodings.
REQ-031 The block SHALL be a single module; if split, the only sub-module SHALL be timer_fsm (state plus COUNT datapath).

Verification
REQ-032 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at E0 -> COUNT reads 5 after E2, IRQ rises after E7, CTRL reads 0x8; IRQ held until a PRESET write drops it next cycle.
REQ-033 PRESET=3, CTRL=0xB (auto-reload, IM) -> IRQ one-cycle pulses every 6 cycles, 10 consecutive periods.
REQ-034 CTRL=0x1 (IM=0), PRESET=2 -> expiry occurs (COUNT 0, EN 0) but IRQ stays 0; later CTRL write 0x8 does not raise IRQ (flag cleared by the write).
REQ-035 During CNT with COUNT=100, write CTRL=0x8 -> next edge IDLE, COUNT frozen at 99; rewrite 0x9 -> COUNT reloads PRESET.
REQ-036 rst pulse mid-count with IRQ high -> next cycle all registers 0, IRQ 0; DEV_ID read returns 32'h0000_7133.
